// File: rtl/multibyte_add_seq_pkg.sv
// Shared types and constants for the byte-serial add/subtract sequencer.
// Imported by the interface, the adder and the top.
package add_seq_pkg;
    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/multibyte_add_seq_if.sv
// Operand/result handshake bundle; master is the requester, slave is the sequencer.
// Both directions use valid/ready; the slave holds results until out_ready.
interface multibyte_add_seq_if #(parameter int NBYTES = 4);
    import add_seq_pkg::*;
    localparam int W = BYTE_W * NBYTES;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         overflow;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, overflow
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, overflow
    );
endinterface

// File: rtl/multibyte_add_seq_cla.sv
// Purely combinational 8-bit carry-lookahead adder; zero latency, no handshake.
// Every carry is a flat sum-of-products of generate/propagate terms and C0.
module CarryLookaheadAdder
    import add_seq_pkg::*;
(
    input  logic [BYTE_W-1:0] X,
    input  logic [BYTE_W-1:0] Y,
    input  logic              C0,
    output logic [BYTE_W-1:0] sum,
    output logic              carry_out
);
    logic [BYTE_W-1:0] p;
    logic [BYTE_W-1:0] g;
    logic [BYTE_W:0]   c;
    logic              acc;
    logic              prop;

    assign p = X ^ Y;
    assign g = X & Y;

    // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]C0, built without a ripple chain
    always_comb begin
        c    = '0;
        acc  = 1'b0;
        prop = 1'b1;
        c[0] = C0;
        for (int i = 0; i < BYTE_W; i++) begin
            acc  = 1'b0;
            prop = 1'b1;
            for (int j = i; j >= 0; j--) begin
                acc  = acc | (g[j] & prop);
                prop = prop & p[j];
            end
            c[i+1] = acc | (prop & C0);
        end
    end

    assign sum       = p ^ c[BYTE_W-1:0];
    assign carry_out = c[BYTE_W];
endmodule

// File: rtl/multibyte_add_seq.sv
// Byte-serial NBYTES-wide add/sub over one 8-bit CLA; result NBYTES cycles after accept.
// Accepts only in IDLE; the result is held in DONE until out_ready.
module multibyte_add_seq
    import add_seq_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input logic                 clk,
    input logic                 rst,
    multibyte_add_seq_if.slave  bus
);
    localparam int W     = BYTE_W * NBYTES;
    localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    state_t            state;
    logic [W-1:0]      op_a;
    logic [W-1:0]      op_b;
    logic [W-1:0]      res;
    logic              carry;
    logic [IDX_W-1:0]  idx;
    logic              cout_q;
    logic              ovf_q;

    logic [BYTE_W-1:0] byte_sum;
    logic              c8;
    logic [W-1:0]      res_next;

    CarryLookaheadAdder u_cla (
        .X         (op_a[BYTE_W-1:0]),
        .Y         (op_b[BYTE_W-1:0]),
        .C0        (carry),
        .sum       (byte_sum),
        .carry_out (c8)
    );

    // New byte enters at the top so the LSB-first stream lands in place after NBYTES shifts
    assign res_next = (res >> BYTE_W) | (W'(byte_sum) << (W - BYTE_W));

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            op_a   <= '0;
            op_b   <= '0;
            res    <= '0;
            carry  <= 1'b0;
            idx    <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        op_a  <= bus.a;
                        op_b  <= bus.sub ? ~bus.b : bus.b;
                        carry <= bus.sub ? ~bus.cin : bus.cin;
                        idx   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    res   <= res_next;
                    carry <= c8;
                    op_a  <= op_a >> BYTE_W;
                    op_b  <= op_b >> BYTE_W;
                    idx   <= idx + IDX_W'(1);
                    if (idx == IDX_W'(NBYTES - 1)) begin
                        cout_q <= c8;
                        ovf_q  <= (op_a[BYTE_W-1] == op_b[BYTE_W-1]) &&
                                  (byte_sum[BYTE_W-1] != op_a[BYTE_W-1]);
                        state  <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.sum       = res;
    assign bus.cout      = cout_q;
    assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_multibyte_add_seq.sv
// Randomised and directed bench for multibyte_add_seq at NBYTES=4 against an arithmetic model.
// Drives and samples 1 time unit after each rising edge.
module tb_multibyte_add_seq;
    localparam int NB = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_pass  = 0;
    int   n_total = 0;

    multibyte_add_seq_if #(.NBYTES(NB)) bus ();

    multibyte_add_seq #(.NBYTES(NB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference: signed/unsigned arithmetic on whole words
    function automatic void model(input logic [31:0] ma, input logic [31:0] mb,
                                  input logic mc, input logic ms,
                                  output logic [31:0] es, output logic ec, output logic eo);
        longint sa;
        longint sb;
        longint t;
        logic [32:0] wide;
        sa = longint'($signed(ma));
        sb = longint'($signed(mb));
        if (ms) begin
            t  = sa - sb - longint'(mc);
            es = ma - mb - 32'(mc);
            ec = ({1'b0, ma} >= ({1'b0, mb} + 33'(mc)));
        end else begin
            t    = sa + sb + longint'(mc);
            wide = {1'b0, ma} + {1'b0, mb} + 33'(mc);
            es   = wide[31:0];
            ec   = wide[32];
        end
        eo = (t > 64'sd2147483647) || (t < -64'sd2147483648);
    endfunction

    task automatic do_op(input logic [31:0] ia, input logic [31:0] ib,
                         input logic icin, input logic isub,
                         output logic [31:0] osum, output logic ocout,
                         output logic oovf, output int lat);
        int w;
        bus.in_valid = 1'b1;
        bus.a = ia;
        bus.b = ib;
        bus.cin = icin;
        bus.sub = isub;
        w = 0;
        while (!bus.in_ready && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        @(posedge clk); #1;
        // Operands must be ignored after the accepting edge
        bus.in_valid = 1'b0;
        bus.a = $urandom;
        bus.b = $urandom;
        bus.cin = 1'($urandom);
        bus.sub = 1'($urandom);
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        osum  = bus.sum;
        ocout = bus.cout;
        oovf  = bus.overflow;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.cin = 1'b0;
        bus.sub = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        n_total++;
        if ({bus.in_ready, bus.out_valid, bus.cout, bus.overflow} !== 4'b1000 || bus.sum !== 32'h0)
            $display("FAIL reset: rdy/vld/cout/ovf=%b%b%b%b sum=%h, need 1000 sum=0",
                     bus.in_ready, bus.out_valid, bus.cout, bus.overflow, bus.sum);
        else n_pass++;
    endtask

    task automatic test_directed();
        logic [31:0] ta [4] = '{32'h000000FF, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h00000005};
        logic [31:0] tb [4] = '{32'h00000001, 32'h00000000, 32'h00000001, 32'h00000007};
        logic        tc [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic        tsb[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [31:0] xs [4] = '{32'h00000100, 32'h00000000, 32'h80000000, 32'hFFFFFFFE};
        logic        xc [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic        xo [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [31:0] s;
        logic c, o;
        int lat;
        for (int i = 0; i < 4; i++) begin
            do_op(ta[i], tb[i], tc[i], tsb[i], s, c, o, lat);
            n_total++;
            if (s !== xs[i]) $display("FAIL directed%0d sum: got %h need %h", i, s, xs[i]);
            else n_pass++;
            n_total++;
            if (c !== xc[i]) $display("FAIL directed%0d cout: got %b need %b", i, c, xc[i]);
            else n_pass++;
            n_total++;
            if (o !== xo[i]) $display("FAIL directed%0d overflow: got %b need %b", i, o, xo[i]);
            else n_pass++;
            n_total++;
            if (lat != NB) $display("FAIL directed%0d latency: got %0d need %0d", i, lat, NB);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        logic [31:0] ra, rb, s, es;
        logic rc, rs, c, o, ec, eo;
        int lat;
        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 4 == 0) rb = 32'h80000000 - ra;
            rc = 1'($urandom);
            rs = 1'($urandom);
            model(ra, rb, rc, rs, es, ec, eo);
            do_op(ra, rb, rc, rs, s, c, o, lat);
            n_total++;
            if (s !== es || c !== ec || o !== eo || lat != NB)
                $display("FAIL random%0d %h %s %h cin=%b: got sum=%h c=%b v=%b lat=%0d need sum=%h c=%b v=%b lat=%0d",
                         i, ra, rs ? "-" : "+", rb, rc, s, c, o, lat, es, ec, eo, NB);
            else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] s0, s, es;
        logic c0, o0, c, o, ec, eo;
        int lat;
        bus.in_valid = 1'b1;
        bus.a = 32'h7FFF0000;
        bus.b = 32'h7FFF0001;
        bus.cin = 1'b1;
        bus.sub = 1'b0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        s0 = bus.sum; c0 = bus.cout; o0 = bus.overflow;
        model(32'h7FFF0000, 32'h7FFF0001, 1'b1, 1'b0, es, ec, eo);
        n_total++;
        if (s0 !== es || c0 !== ec || o0 !== eo)
            $display("FAIL bp_result: got %h/%b/%b need %h/%b/%b", s0, c0, o0, es, ec, eo);
        else n_pass++;
        for (int k = 0; k < 3; k++) begin
            bus.in_valid = (k == 1);
            bus.a = 32'h11111111;
            bus.b = 32'h22222222;
            @(posedge clk); #1;
            n_total++;
            if (!bus.out_valid || bus.in_ready || bus.sum !== s0 || bus.cout !== c0 || bus.overflow !== o0)
                $display("FAIL bp_hold%0d: vld=%b rdy=%b sum=%h c=%b v=%b need vld=1 rdy=0 %h/%b/%b",
                         k, bus.out_valid, bus.in_ready, bus.sum, bus.cout, bus.overflow, s0, c0, o0);
            else n_pass++;
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        n_total++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0)
            $display("FAIL bp_release: rdy=%b vld=%b need rdy=1 vld=0", bus.in_ready, bus.out_valid);
        else n_pass++;
        repeat (6) @(posedge clk);
        #1;
        n_total++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0)
            $display("FAIL bp_not_queued: rdy=%b vld=%b need rdy=1 vld=0", bus.in_ready, bus.out_valid);
        else n_pass++;
        do_op(32'hDEADBEEF, 32'h01234567, 1'b0, 1'b1, s, c, o, lat);
        model(32'hDEADBEEF, 32'h01234567, 1'b0, 1'b1, es, ec, eo);
        n_total++;
        if (s !== es || c !== ec || o !== eo || lat != NB)
            $display("FAIL bp_next_op: got %h/%b/%b lat=%0d need %h/%b/%b lat=%0d", s, c, o, lat, es, ec, eo, NB);
        else n_pass++;
    endtask

    task automatic test_reset_mid_run();
        logic [31:0] s;
        logic c, o;
        int lat;
        bus.in_valid = 1'b1;
        bus.a = 32'hFFFFFFFF;
        bus.b = 32'hFFFFFFFF;
        bus.cin = 1'b1;
        bus.sub = 1'b0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_total++;
        if ({bus.in_ready, bus.out_valid, bus.cout, bus.overflow} !== 4'b1000 || bus.sum !== 32'h0)
            $display("FAIL mid_run_reset: rdy/vld/cout/ovf=%b%b%b%b sum=%h need 1000 sum=0",
                     bus.in_ready, bus.out_valid, bus.cout, bus.overflow, bus.sum);
        else n_pass++;
        repeat (5) @(posedge clk);
        #1;
        n_total++;
        if (bus.out_valid !== 1'b0)
            $display("FAIL aborted_no_result: vld=%b need 0", bus.out_valid);
        else n_pass++;
        do_op(32'h12345678, 32'h11111111, 1'b0, 1'b0, s, c, o, lat);
        n_total++;
        if (s !== 32'h23456789 || c !== 1'b0 || o !== 1'b0 || lat != NB)
            $display("FAIL after_reset_op: got %h/%b/%b lat=%0d need 23456789/0/0 lat=%0d", s, c, o, lat, NB);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/multibyte_add_seq.md
# multibyte_add_seq

Sequencer that performs NBYTES-wide add/subtract by time-multiplexing one 8-bit carry-lookahead adder, one byte per cycle, least-significant byte first. The carry from each byte is registered and fed back as the next byte's carry-in. Operands enter through a valid/ready handshake and results leave through one. The block sits between a requester and the shared 8-bit adder datapath, trading latency for area on wide arithmetic.

## Interface
- NBYTES, 4, operand width in bytes (≥1); data width W = 8*NBYTES
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operands present
- in_ready  out  1  block can accept operands (high only in IDLE)
- a  in  W  operand A
- b  in  W  operand B
- cin  in  1  carry-in (add) / borrow-in (sub)
- sub  in  1  0: a+b+cin; 1: a−b−cin
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- sum  out  W  result
- cout  out  1  raw adder carry out of MSB (sub: 1 = no borrow)
- overflow  out  1  signed two's-complement overflow

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid&in_ready:
  - capture a→opA
  - capture (sub ? ~b : b)→opB
  - carry ← sub ? ~cin : cin
  - idx ← 0
  - go RUN
- RUN: the adder sees opA[7:0], opB[7:0] and carry.
  - Each cycle: shift the sum byte into the top of the result shift register, carry ← C8, shift opA/opB right by 8, idx++.
  - When idx==NBYTES−1, also latch cout ← C8 and overflow ← (A7==B7)&&(S7!=A7), using the MSBs of the final byte (post-inversion B). Go DONE.
- DONE: out_valid=1; sum, cout and overflow are held stable. On out_ready go IDLE.
- a, b, cin and sub are sampled only at the accepting edge. Later changes are ignored.
- in_valid while not in IDLE is ignored; it is not queued.
- sum is meaningful only while out_valid=1.
- Reset values (including reset mid-RUN or mid-DONE): state IDLE, in_ready=1, out_valid=0, sum=0, cout=0, overflow=0, idx=0, carry=0. An aborted operation produces no result.
- NBYTES=1: RUN lasts one cycle.

## Timing
- Accepting edge E0. Byte k is computed in the cycle after E0+k and registered at edge E0+k+1.
- out_valid is high from the cycle after edge E0+NBYTES. Latency is NBYTES cycles from accept to out_valid.
- Output is consumed at edge with out_valid&out_ready. in_ready rises the following cycle.
- Minimum cadence: NBYTES+2 cycles per operation. Accept and result cannot occur in the same cycle.
- The adder path is combinational within a single cycle. The carry register is the only feedback.

## Structure
- Package add_seq_pkg: state enum {IDLE, RUN, DONE}, BYTE_W=8 constant.
- One sub-module: a single instance of the existing 8-bit CarryLookaheadAdder (X, Y, C0 → sum, carry_out). There is no other arithmetic in the block.
- Idx counter width: $clog2(NBYTES) with a minimum of 1.

## Test plan (NBYTES=4)
- 0x000000FF + 0x00000001, cin=0, sub=0 → sum 0x00000100, cout 0, overflow 0; out_valid exactly 4 cycles after accept.
- 0xFFFFFFFF + 0x00000000, cin=1 → sum 0x00000000, cout 1, overflow 0 (carry ripples across all four bytes).
- 0x7FFFFFFF + 0x00000001, cin=0 → sum 0x80000000, cout 0, overflow 1.
- sub=1: 0x00000005 − 0x00000007, cin=0 → sum 0xFFFFFFFE, cout 0 (borrow), overflow 0.
- Backpressure: hold out_ready=0 for 3 cycles in DONE.
  - out_valid, sum, cout and overflow stay stable; in_ready stays 0.
  - in_valid pulsed in DONE is not accepted.
  - After out_ready=1, in_ready=1 next cycle and the next operation completes correctly.
- rst=1 for one cycle after 2 bytes of RUN → next cycle: in_ready 1, out_valid 0, sum 0, cout 0. A following 0x12345678 + 0x11111111 yields 0x23456789.
